// File: rtl/updown_counter_pkg.sv
// -----------------------------------------------------------------------------
// updown_counter_pkg
// Shared types and defaults for the parametrised up/down counter.
//   dir_e  : count direction (ud input)
//   mode_e : end-of-range behaviour (sat_mode input)
//   DEF_WIDTH / DEF_PRESCALE : default parameter values for the counter.
// -----------------------------------------------------------------------------
package updown_counter_pkg;

   typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
   typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_PRESCALE = 5_000_000;

endpackage : updown_counter_pkg

// File: rtl/updown_counter_param_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Clock-enable generator: produces a one-cycle tick every PRESCALE enabled
// clock cycles. Only built when UPDOWN_COUNTER_PRESCALE_EN is defined.
// Ports:
//   clk  in  1  clock
//   rst  in  1  synchronous active-low reset (clears the phase counter)
//   en   in  1  advance enable; en=0 freezes the phase counter
//   tick out 1  high while the phase counter sits at PRESCALE-1
// -----------------------------------------------------------------------------
`ifdef UPDOWN_COUNTER_PRESCALE_EN
module tick_prescaler
   import updown_counter_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int             CW   = $clog2(PRESCALE) + 1;
   localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] phase_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         phase_reg <= '0;
      end else if (en) begin
         phase_reg <= (phase_reg == LAST) ? '0 : phase_reg + CW'(1);
      end
   end

   // Tick is decoded from the phase so it lines up with the cycle the
   // counter sits at its last value; the parent gates it with en.
   assign tick = (phase_reg == LAST);

endmodule : tick_prescaler
`endif

// File: rtl/updown_counter_param.sv
// -----------------------------------------------------------------------------
// updown_counter_param
// Parametrised up/down counter with enable, parallel load, wrap/saturate
// mode, terminal-count and wrap / saturation-hit pulses.
// Optional prescaler: define UPDOWN_COUNTER_PRESCALE_EN to step only once
// every PRESCALE enabled cycles; otherwise one step per enabled clock.
// Parameters: WIDTH, MODULUS (2 <= MODULUS <= 2**WIDTH), PRESCALE (>= 1).
// Ports:
//   clk      in   1      clock
//   rst      in   1      synchronous active-low reset
//   en       in   1      count enable (load ignores it)
//   ud       in   1      1 = up, 0 = down
//   sat_mode in   1      1 = saturate, 0 = wrap
//   load     in   1      parallel load strobe (beats stepping)
//   load_val in   WIDTH  value to load, clamped to MODULUS-1
//   count    out  WIDTH  registered count
//   tc       out  1      combinational terminal count for the current direction
//   wrap     out  1      one-cycle pulse after a wrapping step
//   sat_hit  out  1      one-cycle pulse after a step blocked by saturation
// -----------------------------------------------------------------------------
module updown_counter_param
   import updown_counter_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MODULUS  = 2 ** WIDTH,
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ud,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             sat_hit
);

   // One extra bit so that MODULUS itself (up to 2**WIDTH) and the borrow of
   // 0-1 are representable without aliasing.
   localparam logic [WIDTH:0] MOD_W = (WIDTH + 1)'(MODULUS);
   localparam logic [WIDTH:0] MAX_W = (WIDTH + 1)'(MODULUS - 1);
   localparam logic [WIDTH:0] ONE_W = (WIDTH + 1)'(1);

   logic             tick;
   logic             step;
   dir_e             dir;
   mode_e            mode;

   logic [WIDTH-1:0] count_reg, count_next;
   logic             wrap_reg, wrap_next;
   logic             sat_hit_reg, sat_hit_next;

   logic [WIDTH:0]   count_w;
   logic [WIDTH:0]   sum_up;
   logic [WIDTH:0]   diff_down;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (tick)
   );
`else
   // PRESCALE is always >= 1, so this is a constant 1: one step per clock.
   assign tick = (PRESCALE >= 1);
`endif

   assign step = en && tick;
   assign dir  = dir_e'(ud);
   assign mode = mode_e'(sat_mode);

   assign count_w   = {1'b0, count_reg};
   assign sum_up    = count_w + ONE_W;
   assign diff_down = count_w - ONE_W;

   always_comb begin
      count_next   = count_reg;
      wrap_next    = 1'b0;
      sat_hit_next = 1'b0;
      if (load) begin
         count_next = ({1'b0, load_val} >= MOD_W) ? MAX_W[WIDTH-1:0] : load_val;
      end else if (step) begin
         if (dir == DIR_UP) begin
            // Reaching MODULUS means we were already at the top.
            if (sum_up == MOD_W) begin
               if (mode == MODE_SAT) begin
                  sat_hit_next = 1'b1;
               end else begin
                  count_next = '0;
                  wrap_next  = 1'b1;
               end
            end else begin
               count_next = sum_up[WIDTH-1:0];
            end
         end else begin
            // A borrow out of the extra bit means we were at zero.
            if (diff_down[WIDTH]) begin
               if (mode == MODE_SAT) begin
                  sat_hit_next = 1'b1;
               end else begin
                  count_next = MAX_W[WIDTH-1:0];
                  wrap_next  = 1'b1;
               end
            end else begin
               count_next = diff_down[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_reg   <= '0;
         wrap_reg    <= 1'b0;
         sat_hit_reg <= 1'b0;
      end else begin
         count_reg   <= count_next;
         wrap_reg    <= wrap_next;
         sat_hit_reg <= sat_hit_next;
      end
   end

   assign count   = count_reg;
   assign wrap    = wrap_reg;
   assign sat_hit = sat_hit_reg;
   assign tc      = (dir == DIR_UP) ? (count_w == MAX_W) : (count_reg == '0);

endmodule : updown_counter_param

// File: tb/tb_updown_counter_param.sv
// -----------------------------------------------------------------------------
// tb_updown_counter_param
// Self-checking bench for updown_counter_param (WIDTH=8). Without
// UPDOWN_COUNTER_PRESCALE_EN the DUT uses MODULUS=10; with it, MODULUS=256
// and PRESCALE=4. A plain-integer reference model tracks the expected
// outputs; a negedge process compares every cycle, and directed literal
// checks pin the model to hand-worked values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_updown_counter_param;
   import updown_counter_pkg::*;

   localparam int WIDTH = 8;
`ifdef UPDOWN_COUNTER_PRESCALE_EN
   localparam int M  = 256;
   localparam int PS = 4;
`else
   localparam int M  = 10;
   localparam int PS = 1;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en = 1'b0, ud = 1'b1, sat_mode = 1'b0, load = 1'b0;
   logic [WIDTH-1:0] load_val = '0;
   logic [WIDTH-1:0] count;
   logic             tc, wrap, sat_hit;

   int n_vec  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // reference model state
   int m_cnt = 0, m_phase = 0;
   bit m_wrap = 0, m_sat = 0;

   always #5 clk = ~clk;

   updown_counter_param #(
      .WIDTH    (WIDTH),
      .MODULUS  (M),
      .PRESCALE (PS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .ud       (ud),
      .sat_mode (sat_mode),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tc       (tc),
      .wrap     (wrap),
      .sat_hit  (sat_hit)
   );

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_edge();
      bit tick_now;
      if (!rst) begin
         m_cnt = 0; m_wrap = 0; m_sat = 0; m_phase = 0;
         return;
      end
`ifdef UPDOWN_COUNTER_PRESCALE_EN
      tick_now = (m_phase == PS - 1);
      if (en) m_phase = (m_phase + 1) % PS;
`else
      tick_now = 1'b1;
`endif
      m_wrap = 0;
      m_sat  = 0;
      if (load) begin
         m_cnt = (int'(load_val) > M - 1) ? M - 1 : int'(load_val);
      end else if (en && tick_now) begin
         if (ud) begin
            if (m_cnt < M - 1)  m_cnt = m_cnt + 1;
            else if (sat_mode)  m_sat = 1;
            else begin m_cnt = 0; m_wrap = 1; end
         end else begin
            if (m_cnt > 0)      m_cnt = m_cnt - 1;
            else if (sat_mode)  m_sat = 1;
            else begin m_cnt = M - 1; m_wrap = 1; end
         end
      end
   endtask

   // One clock with the given inputs; returns 1 ns after the edge.
   task automatic cyc(input bit r, input bit e, input bit u, input bit s,
                      input bit l, input int lv);
      rst = r; en = e; ud = u; sat_mode = s; load = l; load_val = WIDTH'(lv);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("count",   int'(count),   m_cnt);
         check("wrap",    int'(wrap),    int'(m_wrap));
         check("sat_hit", int'(sat_hit), int'(m_sat));
         check("tc", int'(tc), int'((ud && m_cnt == M - 1) || (!ud && m_cnt == 0)));
      end
   end

   initial begin
      // Reset with en and load asserted: reset must win.
      cyc(0, 1, 1, 0, 1, 5);
      cyc(0, 1, 1, 0, 1, 5);
      chk_en = 1'b1;
      check("lit_rst_count", int'(count), 0);
      check("lit_rst_wrap",  int'(wrap),  0);
      check("lit_rst_sat",   int'(sat_hit), 0);

`ifdef UPDOWN_COUNTER_PRESCALE_EN
      // First step lands PRESCALE clocks after release.
      for (int k = 1; k <= 12; k++) begin
         cyc(1, 1, 1, 0, 0, 0);
         if (k == 3)  check("lit_ps_clk3",  int'(count), 0);
         if (k == 4)  check("lit_ps_clk4",  int'(count), 1);
         if (k == 8)  check("lit_ps_clk8",  int'(count), 2);
         if (k == 12) check("lit_ps_clk12", int'(count), 3);
      end
      // Two enabled cycles, three frozen, then the step is 3 clk late.
      cyc(1, 1, 1, 0, 0, 0);
      cyc(1, 1, 1, 0, 0, 0);
      repeat (3) cyc(1, 0, 1, 0, 0, 0);
      cyc(1, 1, 1, 0, 0, 0);
      check("lit_ps_frozen", int'(count), 3);
      cyc(1, 1, 1, 0, 0, 0);
      check("lit_ps_delayed", int'(count), 4);
`else
      cyc(1, 1, 1, 0, 0, 0);
      check("lit_first_step", int'(count), 1);

      // Wrap up from 8.
      cyc(1, 1, 1, 0, 1, 8);
      check("lit_load8", int'(count), 8);
      cyc(1, 1, 1, 0, 0, 0);
      check("lit_up9", int'(count), 9);
      check("lit_tc9", int'(tc), 1);
      cyc(1, 1, 1, 0, 0, 0);
      check("lit_wrap0",  int'(count), 0);
      check("lit_wrap_p", int'(wrap),  1);
      cyc(1, 1, 1, 0, 0, 0);
      check("lit_after1", int'(count), 1);
      check("lit_wrap_end", int'(wrap), 0);

      // Clamp on load, then wrap down.
      cyc(1, 1, 1, 0, 1, 200);
      check("lit_clamp", int'(count), 9);
      cyc(1, 0, 0, 0, 1, 0);
      cyc(1, 1, 0, 0, 0, 0);
      check("lit_wrapdn",   int'(count), 9);
      check("lit_wrapdn_p", int'(wrap),  1);

      // Saturation at both ends.
      cyc(1, 1, 1, 1, 0, 0);
      check("lit_sat_top",   int'(count),   9);
      check("lit_sat_top_p", int'(sat_hit), 1);
      cyc(1, 1, 1, 1, 0, 0);
      check("lit_sat_top2",  int'(sat_hit), 1);
      cyc(1, 1, 0, 1, 1, 0);
      cyc(1, 1, 0, 1, 0, 0);
      check("lit_sat_bot",   int'(count),   0);
      check("lit_sat_bot_p", int'(sat_hit), 1);

      // Load beats step; en=0 holds.
      cyc(1, 1, 1, 0, 1, 5);
      check("lit_load_prio", int'(count), 5);
      repeat (20) cyc(1, 0, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0);
      check("lit_hold5", int'(count), 5);
`endif

      // Randomised run: mostly stepping, some loads, rare resets.
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 99) != 0,
             $urandom_range(0, 9) < 8,
             $urandom_range(0, 1),
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 255));
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_updown_counter_param
